// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle LEGv8 control unit: FSM states,
// control-word field map, opcode match patterns, ALU codes and branch conditions.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_ILLEGAL,
    OP_ADD,
    OP_SUB,
    OP_ADDI,
    OP_LDUR,
    OP_STUR,
    OP_B,
    OP_CBZ,
    OP_BCOND
  } op_e;

  // Control-word field positions, LSB first
  localparam int CW_FIELD_BITS = 31;
  localparam int PS_LSB = 0;
  localparam int PS_W   = 2;
  localparam int IL_LSB = 2;
  localparam int RW_LSB = 3;
  localparam int REG_W  = 5;
  localparam int DA_LSB = 4;
  localparam int SA_LSB = 9;
  localparam int SB_LSB = 14;
  localparam int FS_LSB = 19;
  localparam int FS_W   = 5;
  localparam int BS_LSB = 24;
  localparam int MW_LSB = 25;
  localparam int MR_LSB = 26;
  localparam int C0_LSB = 27;
  localparam int SL_LSB = 28;
  localparam int MD_LSB = 29;
  localparam int MD_W   = 2;

  // PC-select and memory-data-select codes
  localparam logic [PS_W-1:0] PS_PC4 = 2'b01;
  localparam logic [PS_W-1:0] PS_PCK = 2'b10;
  localparam logic [MD_W-1:0] MD_MEM = 2'b01;

  // ALU function codes
  localparam logic [FS_W-1:0] FS_ADD = 5'b00000;
  localparam logic [FS_W-1:0] FS_SUB = 5'b00101;

  // Opcode patterns on instruction[31:21]; masked forms ignore immediate bits
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_ADDI  = 11'b10010001000;
  localparam logic [10:0] MSK_ADDI  = 11'b11111111110;
  localparam logic [10:0] OPC_B     = 11'b00010100000;
  localparam logic [10:0] MSK_B     = 11'b11111100000;
  localparam logic [10:0] OPC_CBZ   = 11'b10110100000;
  localparam logic [10:0] OPC_BCOND = 11'b01010100000;
  localparam logic [10:0] MSK_CMP   = 11'b11111111000;

  // B.cond condition codes that the unit evaluates
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;

  function automatic op_e decode_op(input logic [10:0] opc);
    if (opc == OPC_ADD)                           return OP_ADD;
    else if (opc == OPC_SUB)                      return OP_SUB;
    else if (opc == OPC_LDUR)                     return OP_LDUR;
    else if (opc == OPC_STUR)                     return OP_STUR;
    else if ((opc & MSK_ADDI) == OPC_ADDI)        return OP_ADDI;
    else if ((opc & MSK_B) == OPC_B)              return OP_B;
    else if ((opc & MSK_CMP) == OPC_CBZ)          return OP_CBZ;
    else if ((opc & MSK_CMP) == OPC_BCOND)        return OP_BCOND;
    else                                          return OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the datapath and the control unit: IR, status flags,
// memory handshake in; control word, constant and debug state out.
interface multicycle_control_unit_if #(
  parameter int CW_BITS = 31,
  parameter int K_BITS  = 64
);
  logic [31:0]        instruction;
  logic [4:0]         status;
  logic               mem_ready;
  logic [CW_BITS-1:0] controlWord;
  logic [K_BITS-1:0]  K;
  logic [2:0]         state;
  logic               illegal;

  modport master (
    output instruction, status, mem_ready,
    input  controlWord, K, state, illegal
  );

  modport slave (
    input  instruction, status, mem_ready,
    output controlWord, K, state, illegal
  );
endinterface

// File: rtl/k_generator.sv
// Combinational immediate extraction: picks and extends the immediate field
// belonging to the instruction class found in instruction[31:21].
module k_generator
  import cu_pkg::*;
#(
  parameter int K_BITS = 64
) (
  input  logic [31:0]       instruction,
  output logic [K_BITS-1:0] K
);

  op_e op;

  assign op = decode_op(instruction[31:21]);

  // Select and extend the immediate for the decoded class
  always_comb begin
    K = '0;
    case (op)
      OP_ADDI:           K = K_BITS'(instruction[21:10]);
      OP_LDUR, OP_STUR:  K = K_BITS'($signed(instruction[20:12]));
      OP_B:              K = K_BITS'($signed({instruction[25:0], 2'b00}));
      OP_CBZ, OP_BCOND:  K = K_BITS'($signed({instruction[23:5], 2'b00}));
      default:           K = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM, waits on mem_ready and traps on unknown opcodes.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int CW_BITS = 31,
  parameter int K_BITS  = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  multicycle_control_unit_if.slave    bus
);

  state_e                   state_q, state_d;
  logic [CW_FIELD_BITS-1:0] cw;
  logic [K_BITS-1:0]        k_raw;
  op_e                      op;
  logic [4:0]               rn, rm, rt_rd;
  logic [3:0]               cond;
  logic                     rb_zero, flag_v, flag_n, flag_z;
  logic                     cond_taken;
  logic                     unused_carry;

  assign op      = decode_op(bus.instruction[31:21]);
  assign rn      = bus.instruction[9:5];
  assign rm      = bus.instruction[20:16];
  assign rt_rd   = bus.instruction[4:0];
  assign cond    = bus.instruction[3:0];
  assign rb_zero = bus.status[4];
  assign flag_v  = bus.status[3];
  assign flag_n  = bus.status[1];
  assign flag_z  = bus.status[0];
  // No supported condition looks at the carry flag
  assign unused_carry = bus.status[2];

  // Evaluate the B.cond condition; unsupported codes are never taken
  always_comb begin
    cond_taken = 1'b0;
    case (cond)
      COND_EQ: cond_taken = flag_z;
      COND_NE: cond_taken = ~flag_z;
      COND_GE: cond_taken = (flag_n == flag_v);
      COND_LT: cond_taken = (flag_n != flag_v);
      default: cond_taken = 1'b0;
    endcase
  end

  // Next-state and control-word generation for the current state
  always_comb begin
    state_d = state_q;
    cw      = '0;
    case (state_q)
      ST_FETCH: begin
        cw[MR_LSB] = 1'b1;
        if (bus.mem_ready) begin
          cw[IL_LSB]            = 1'b1;
          cw[PS_LSB +: PS_W]    = PS_PC4;
          state_d               = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cw[SA_LSB +: REG_W] = rn;
        cw[SB_LSB +: REG_W] = (op == OP_STUR || op == OP_CBZ) ? rt_rd : rm;
        state_d             = (op == OP_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_ADD, OP_SUB: begin
            cw[RW_LSB]          = 1'b1;
            cw[DA_LSB +: REG_W] = rt_rd;
            cw[SA_LSB +: REG_W] = rn;
            cw[SB_LSB +: REG_W] = rm;
            cw[FS_LSB +: FS_W]  = (op == OP_SUB) ? FS_SUB : FS_ADD;
            cw[C0_LSB]          = (op == OP_SUB);
            cw[SL_LSB]          = 1'b1;
          end
          OP_ADDI: begin
            cw[RW_LSB]          = 1'b1;
            cw[DA_LSB +: REG_W] = rt_rd;
            cw[SA_LSB +: REG_W] = rn;
            cw[FS_LSB +: FS_W]  = FS_ADD;
            cw[BS_LSB]          = 1'b1;
            cw[SL_LSB]          = 1'b1;
          end
          OP_LDUR, OP_STUR: begin
            cw[SA_LSB +: REG_W] = rn;
            cw[FS_LSB +: FS_W]  = FS_ADD;
            cw[BS_LSB]          = 1'b1;
            state_d             = ST_MEM;
          end
          OP_B: begin
            cw[PS_LSB +: PS_W] = PS_PCK;
          end
          OP_CBZ: begin
            // Rt is routed to B so the datapath can report RB==0
            cw[SB_LSB +: REG_W] = rt_rd;
            if (rb_zero) cw[PS_LSB +: PS_W] = PS_PCK;
          end
          OP_BCOND: begin
            if (cond_taken) cw[PS_LSB +: PS_W] = PS_PCK;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Keep the effective address on the ALU for the whole access
        cw[SA_LSB +: REG_W] = rn;
        cw[FS_LSB +: FS_W]  = FS_ADD;
        cw[BS_LSB]          = 1'b1;
        if (op == OP_LDUR) begin
          cw[MR_LSB] = 1'b1;
          if (bus.mem_ready) begin
            cw[MD_LSB +: MD_W]  = MD_MEM;
            cw[RW_LSB]          = 1'b1;
            cw[DA_LSB +: REG_W] = rt_rd;
          end
        end else if (op == OP_STUR) begin
          cw[MW_LSB]          = 1'b1;
          cw[SB_LSB +: REG_W] = rt_rd;
        end
        if (bus.mem_ready || (op != OP_LDUR && op != OP_STUR)) state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  k_generator #(.K_BITS(K_BITS)) u_k_generator (
    .instruction (bus.instruction),
    .K           (k_raw)
  );

  assign bus.controlWord = reset ? '0 : CW_BITS'(cw);
  assign bus.K           = reset ? '0 : k_raw;
  assign bus.state       = reset ? ST_FETCH : state_q;
  assign bus.illegal     = ~reset && (state_q == ST_TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each driven cycle pushes the
// expected outputs; a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [30:0] cw;
    logic [30:0] msk;
    logic [63:0] k;
    logic        ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t cur;

  logic [30:0] F, W, FULL, MEMM, STM;

  localparam logic [31:0] I_ADD  = 32'h8B020023;
  localparam logic [31:0] I_SUB  = 32'hCB020023;
  localparam logic [31:0] I_ADDI = 32'h91001401;
  localparam logic [31:0] I_LDUR = 32'hF85F8022;
  localparam logic [31:0] I_STUR = 32'hF8004023;
  localparam logic [31:0] I_CBZ  = 32'hB4000045;
  localparam logic [31:0] I_B    = 32'h17FFFFFF;
  localparam logic [31:0] I_BEQ  = 32'h54000040;
  localparam logic [31:0] I_BLT  = 32'h5400004B;
  localparam logic [31:0] I_BGT  = 32'h5400004C;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  multicycle_control_unit_if #(.CW_BITS(31), .K_BITS(64)) bus ();

  multicycle_control_unit #(.CW_BITS(31), .K_BITS(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [30:0] mkcw(input int ps, il, rw, da, sa, sb, fs, bs, mw, mr, c0, sl, md);
    logic [30:0] v;
    v = 31'(ps);
    v = v | (31'(il) << 2)  | (31'(rw) << 3)  | (31'(da) << 4)  | (31'(sa) << 9);
    v = v | (31'(sb) << 14) | (31'(fs) << 19) | (31'(bs) << 24) | (31'(mw) << 25);
    v = v | (31'(mr) << 26) | (31'(c0) << 27) | (31'(sl) << 28) | (31'(md) << 29);
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show during it
  task automatic step(input logic r, input logic [31:0] ins, input logic [4:0] stat,
                      input logic rdy, input string tag, input logic [2:0] es,
                      input logic [30:0] ecw, input logic [30:0] em,
                      input logic [63:0] ek, input logic ei);
    exp_t e;
    @(posedge clock);
    #1;
    reset           = r;
    bus.instruction = ins;
    bus.status      = stat;
    bus.mem_ready   = rdy;
    e.tag = tag; e.st = es; e.cw = ecw; e.msk = em; e.k = ek; e.ill = ei;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      check_eq({cur.tag, "_state"}, 64'(bus.state), 64'(cur.st));
      check_eq({cur.tag, "_cw"}, 64'(bus.controlWord & cur.msk), 64'(cur.cw & cur.msk));
      check_eq({cur.tag, "_k"}, bus.K, cur.k);
      check_eq({cur.tag, "_illegal"}, 64'(bus.illegal), 64'(cur.ill));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instruction = I_ADDI;
    bus.status      = 5'b0;
    bus.mem_ready   = 1'b1;
    FULL = '1;
    F    = mkcw(1,1,0,0,0,0,0,0,0,1,0,0,0);
    W    = mkcw(0,0,0,0,0,0,0,0,0,1,0,0,0);
    MEMM = FULL & ~mkcw(0,0,0,0,31,31,31,1,0,0,0,0,0);
    STM  = FULL & ~mkcw(0,0,0,0,31,0,31,1,0,0,0,0,0);

    // reset: outputs forced quiet even with a K-producing instruction present
    step(1, I_ADDI, 0, 1, "rst0", 0, 0, FULL, 0, 0);
    step(1, I_ADDI, 0, 1, "rst1", 0, 0, FULL, 0, 0);

    // ADD X3,X1,X2
    step(0, I_ADD, 0, 1, "add_f", 0, F, FULL, 0, 0);
    step(0, I_ADD, 0, 1, "add_d", 1, mkcw(0,0,0,0,1,2,0,0,0,0,0,0,0), FULL, 0, 0);
    step(0, I_ADD, 0, 1, "add_e", 2, mkcw(0,0,1,3,1,2,0,0,0,0,0,1,0), FULL, 0, 0);

    // SUB X3,X1,X2
    step(0, I_SUB, 0, 1, "sub_f", 0, F, FULL, 0, 0);
    step(0, I_SUB, 0, 1, "sub_d", 1, mkcw(0,0,0,0,1,2,0,0,0,0,0,0,0), FULL, 0, 0);
    step(0, I_SUB, 0, 1, "sub_e", 2, mkcw(0,0,1,3,1,2,5,0,0,0,1,1,0), FULL, 0, 0);

    // ADDI X1,X0,#5
    step(0, I_ADDI, 0, 1, "addi_f", 0, F, FULL, 5, 0);
    step(0, I_ADDI, 0, 1, "addi_d", 1, 0, FULL, 5, 0);
    step(0, I_ADDI, 0, 1, "addi_e", 2, mkcw(0,0,1,1,0,0,0,1,0,0,0,1,0), FULL, 5, 0);

    // LDUR X2,[X1,#-8] with two not-ready MEM cycles
    step(0, I_LDUR, 0, 1, "ldur_f", 0, F, FULL, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, I_LDUR, 0, 1, "ldur_d", 1, mkcw(0,0,0,0,1,31,0,0,0,0,0,0,0), FULL, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, I_LDUR, 0, 1, "ldur_e", 2, mkcw(0,0,0,0,1,0,0,1,0,0,0,0,0), FULL, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, I_LDUR, 0, 0, "ldur_m0", 3, W, MEMM, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, I_LDUR, 0, 0, "ldur_m1", 3, W, MEMM, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, I_LDUR, 0, 1, "ldur_m2", 3, mkcw(0,0,1,2,0,0,0,0,0,1,0,0,1), MEMM, 64'hFFFF_FFFF_FFFF_FFF8, 0);

    // STUR X3,[X1,#4]
    step(0, I_STUR, 0, 1, "stur_f", 0, F, FULL, 4, 0);
    step(0, I_STUR, 0, 1, "stur_d", 1, mkcw(0,0,0,0,1,3,0,0,0,0,0,0,0), FULL, 4, 0);
    step(0, I_STUR, 0, 1, "stur_e", 2, mkcw(0,0,0,0,1,0,0,1,0,0,0,0,0), FULL, 4, 0);
    step(0, I_STUR, 0, 1, "stur_m", 3, mkcw(0,0,0,0,0,3,0,0,1,0,0,0,0), STM, 4, 0);

    // CBZ X5,+8 taken then not taken
    step(0, I_CBZ, 5'b10000, 1, "cbzt_f", 0, F, FULL, 8, 0);
    step(0, I_CBZ, 5'b10000, 1, "cbzt_d", 1, mkcw(0,0,0,0,2,5,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_CBZ, 5'b10000, 1, "cbzt_e", 2, mkcw(2,0,0,0,0,5,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_CBZ, 5'b00000, 1, "cbzn_f", 0, F, FULL, 8, 0);
    step(0, I_CBZ, 5'b00000, 1, "cbzn_d", 1, mkcw(0,0,0,0,2,5,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_CBZ, 5'b00000, 1, "cbzn_e", 2, mkcw(0,0,0,0,0,5,0,0,0,0,0,0,0), FULL, 8, 0);

    // B -4
    step(0, I_B, 0, 1, "b_f", 0, F, FULL, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, I_B, 0, 1, "b_d", 1, mkcw(0,0,0,0,31,31,0,0,0,0,0,0,0), FULL, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, I_B, 0, 1, "b_e", 2, mkcw(2,0,0,0,0,0,0,0,0,0,0,0,0), FULL, 64'hFFFF_FFFF_FFFF_FFFC, 0);

    // B.EQ taken / not taken, B.LT taken / not taken, B.GT unsupported
    step(0, I_BEQ, 5'b00001, 1, "beqt_f", 0, F, FULL, 8, 0);
    step(0, I_BEQ, 5'b00001, 1, "beqt_d", 1, mkcw(0,0,0,0,2,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BEQ, 5'b00001, 1, "beqt_e", 2, mkcw(2,0,0,0,0,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BEQ, 5'b00000, 1, "beqn_f", 0, F, FULL, 8, 0);
    step(0, I_BEQ, 5'b00000, 1, "beqn_d", 1, mkcw(0,0,0,0,2,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BEQ, 5'b00000, 1, "beqn_e", 2, 0, FULL, 8, 0);
    step(0, I_BLT, 5'b00010, 1, "bltt_f", 0, F, FULL, 8, 0);
    step(0, I_BLT, 5'b00010, 1, "bltt_d", 1, mkcw(0,0,0,0,2,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BLT, 5'b00010, 1, "bltt_e", 2, mkcw(2,0,0,0,0,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BLT, 5'b01010, 1, "bltn_f", 0, F, FULL, 8, 0);
    step(0, I_BLT, 5'b01010, 1, "bltn_d", 1, mkcw(0,0,0,0,2,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BLT, 5'b01010, 1, "bltn_e", 2, 0, FULL, 8, 0);
    step(0, I_BGT, 5'b00000, 1, "bgt_f", 0, F, FULL, 8, 0);
    step(0, I_BGT, 5'b00000, 1, "bgt_d", 1, mkcw(0,0,0,0,2,0,0,0,0,0,0,0,0), FULL, 8, 0);
    step(0, I_BGT, 5'b00000, 1, "bgt_e", 2, 0, FULL, 8, 0);

    // FETCH stalls for three cycles, then the IR loads
    for (int i = 0; i < 3; i++)
      step(0, I_ADD, 0, 0, $sformatf("fwait%0d", i), 0, W, FULL, 0, 0);
    step(0, I_ADD, 0, 1, "fwait_rdy", 0, F, FULL, 0, 0);
    step(0, I_ADD, 0, 1, "fwait_d", 1, mkcw(0,0,0,0,1,2,0,0,0,0,0,0,0), FULL, 0, 0);
    step(0, I_ADD, 0, 1, "fwait_e", 2, mkcw(0,0,1,3,1,2,0,0,0,0,0,1,0), FULL, 0, 0);

    // reset in DECODE drops the ADDI and restarts at FETCH
    step(0, I_ADDI, 0, 1, "mrst_f", 0, F, FULL, 5, 0);
    step(1, I_ADDI, 0, 1, "mrst_r", 0, 0, FULL, 0, 0);
    step(0, I_ADDI, 0, 1, "mrst_f2", 0, F, FULL, 5, 0);
    step(0, I_ADDI, 0, 1, "mrst_d2", 1, 0, FULL, 5, 0);
    step(0, I_ADDI, 0, 1, "mrst_e2", 2, mkcw(0,0,1,1,0,0,0,1,0,0,0,1,0), FULL, 5, 0);

    // illegal opcode traps until reset
    step(0, I_ILL, 0, 1, "ill_f", 0, F, FULL, 0, 0);
    step(0, I_ILL, 0, 1, "ill_d", 1, 0, FULL, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, I_ILL, 5'b11111, 1, $sformatf("trap%0d", i), 4, 0, FULL, 0, 1);
    step(1, I_ILL, 0, 1, "trap_rst", 0, 0, FULL, 0, 0);
    step(0, I_ADD, 0, 1, "post_f", 0, F, FULL, 0, 0);
    step(0, I_ADD, 0, 1, "post_d", 1, mkcw(0,0,0,0,1,2,0,0,0,0,0,0,0), FULL, 0, 0);

    @(negedge clock);
    #1;
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
